hw_nios_pio_seq: RTL and testbench



---
 rtl/hw_nios_pio_seq.sv | 181 ++++++++++++++++++
 tb/tb_hw_nios_pio_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hw_nios_pio_seq.sv
// Avalon-MM PIO slave driving one output pin, either from a manual DATA bit or
// by replaying a programmed pattern. Optional DONE interrupt: HW_NIOS_PIO_SEQ_IRQ_EN.
module hw_nios_pio_seq #(
  parameter int unsigned PERIOD_W   = 24,
  parameter bit          DATA_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
`ifdef HW_NIOS_PIO_SEQ_IRQ_EN
  output logic        irq,
`endif
  output logic        out_port
);

  localparam int unsigned LEN_W = 5;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_PATTERN = 2'd3;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic                data_q, data_d;
  logic                oneshot_q, oneshot_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                done_q, done_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [31:0]         pattern_q, pattern_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic                out_q, out_d;
  logic                irq_ena_rd;

  logic                wr_c;
  logic                wr_ctrl_c;
  logic [PERIOD_W-1:0] reload_c;

  assign wr_c      = chipselect & ~write_n;
  assign wr_ctrl_c = wr_c & (address == ADDR_CTRL);
  // A zero period behaves as one cycle per step.
  assign reload_c  = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

`ifdef HW_NIOS_PIO_SEQ_IRQ_EN
  logic irq_ena_q, irq_ena_d;
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_ena_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      irq_ena_q <= irq_ena_d;
      irq_q     <= done_q & irq_ena_q;
    end
  end

  always_comb begin
    irq_ena_d = irq_ena_q;
    if (wr_ctrl_c) irq_ena_d = writedata[4];
  end

  assign irq_ena_rd = irq_ena_q;
  assign irq        = irq_q;
`else
  assign irq_ena_rd = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      data_q    <= DATA_RESET;
      oneshot_q <= 1'b0;
      len_q     <= '0;
      done_q    <= 1'b0;
      period_q  <= '0;
      pattern_q <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      out_q     <= DATA_RESET;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      oneshot_q <= oneshot_d;
      len_q     <= len_d;
      done_q    <= done_d;
      period_q  <= period_d;
      pattern_q <= pattern_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    oneshot_d = oneshot_q;
    len_d     = len_q;
    done_d    = done_q;
    period_d  = period_q;
    pattern_d = pattern_q;
    idx_d     = idx_q;
    timer_d   = timer_q;

    if (wr_c) begin
      case (address)
        ADDR_DATA:    data_d    = writedata[0];
        ADDR_CTRL: begin
          oneshot_d = writedata[1];
          len_d     = writedata[12:8];
        end
        ADDR_PERIOD:  period_d  = writedata[PERIOD_W-1:0];
        ADDR_PATTERN: pattern_d = writedata;
        default: ;
      endcase
    end

    if (wr_ctrl_c && writedata[3]) done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_ctrl_c && writedata[0]) begin
          state_d = ST_RUN;
          idx_d   = '0;
          timer_d = reload_c;
        end
      end
      ST_RUN: begin
        if (wr_ctrl_c && writedata[0]) begin
          idx_d   = '0;
          timer_d = reload_c;
        end else begin
          // LEN is compared live, so a shrunk LEN ends the sequence at this boundary.
          if (timer_q == '0) begin
            timer_d = reload_c;
            if (idx_q >= len_q) begin
              idx_d = '0;
              if (oneshot_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              idx_d = idx_q + LEN_W'(1);
            end
          end else begin
            timer_d = timer_q - PERIOD_W'(1);
          end
          if (wr_ctrl_c) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin follows the next-state view so writes show up on the following cycle.
  always_comb begin
    out_d = data_d;
    if (state_d == ST_RUN) out_d = pattern_d[idx_d];
  end

  assign out_port = out_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = {31'd0, data_q};
      ADDR_CTRL:    readdata = {19'd0, len_q, 3'd0, irq_ena_rd, 1'b0, done_q, oneshot_q,
                                (state_q == ST_RUN)};
      ADDR_PERIOD:  readdata = 32'(period_q);
      ADDR_PATTERN: readdata = pattern_q;
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hw_nios_pio_seq.sv
// Bench for hw_nios_pio_seq: directed steps plus randomized runs against a
// closed-form step model (step = cycles_since_start / period).
module tb_hw_nios_pio_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_port;
`ifdef HW_NIOS_PIO_SEQ_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  hw_nios_pio_seq dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
`ifdef HW_NIOS_PIO_SEQ_IRQ_EN
    .irq        (irq),
`endif
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Output k cycles after a start write: pattern bit of step k/P, wrapping
  // over LEN+1 steps, or DATA once a one-shot has used up its steps.
  function automatic logic model_out(input logic [31:0] pat, input int period,
                                     input int len, input bit oneshot,
                                     input logic data, input int k);
    int p;
    int step;
    p    = (period == 0) ? 1 : period;
    step = k / p;
    if (oneshot && step > len) return data;
    return pat[step % (len + 1)];
  endfunction

  initial begin
    logic [31:0] rv;
    logic [31:0] pat;
    int          per, len, cyc;
    bit          os;
    logic        dat;

    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_out", 32'(out_port), 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rv);
      chk($sformatf("rst_reg%0d", a), rv, 32'h0);
    end

    // Manual mode and reset back to DATA_RESET.
    wr(2'd0, 32'h1);
    chk("data_out", 32'(out_port), 32'h1);
    rd(2'd0, rv);
    chk("data_rd", rv, 32'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("data_rst_out", 32'(out_port), 32'h0);

    // One-shot 0x5, period 3, LEN=2.
    wr(2'd3, 32'h5);
    wr(2'd2, 32'd3);
    wr(2'd1, 32'h0203);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("os_out_k%0d", k), 32'(out_port), 32'(model_out(32'h5, 3, 2, 1'b1, 1'b0, k)));
      rd(2'd1, rv);
      chk($sformatf("os_done_k%0d", k), 32'(rv[2]), 32'h0);
      tick();
    end
    chk("os_end_out", 32'(out_port), 32'h0);
    rd(2'd1, rv);
    chk("os_end_ctrl", rv, 32'h0206);
    wr(2'd1, 32'h8);
    rd(2'd1, rv);
    chk("os_done_clr", rv, 32'h0);

    // Continuous one-cycle steps, stopped mid-run.
    wr(2'd0, 32'h1);
    wr(2'd2, 32'd0);
    wr(2'd3, 32'h2);
    wr(2'd1, 32'h0101);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tog_k%0d", k), 32'(out_port), 32'(k % 2));
      if (k < 3) tick();
    end
    wr(2'd1, 32'h0);
    chk("stop_out", 32'(out_port), 32'h1);
    rd(2'd1, rv);
    chk("stop_ctrl", rv, 32'h0);

    // Restart from idx 2 of a LEN=3, period-4 continuous run.
    wr(2'd0, 32'h1);
    wr(2'd2, 32'd4);
    wr(2'd3, 32'hE);
    wr(2'd1, 32'h0301);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rs_pre_k%0d", k), 32'(out_port), 32'(model_out(32'hE, 4, 3, 1'b0, 1'b1, k)));
      tick();
    end
    chk("rs_idx2", 32'(out_port), 32'h1);
    wr(2'd1, 32'h0301);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rs_post_k%0d", k), 32'(out_port), 32'(model_out(32'hE, 4, 3, 1'b0, 1'b1, k)));
      tick();
    end
    wr(2'd1, 32'h8);

`ifdef HW_NIOS_PIO_SEQ_IRQ_EN
    // DONE interrupt: LEN=0, period 2, IRQ_ENA.
    wr(2'd2, 32'd2);
    wr(2'd3, 32'h1);
    wr(2'd1, 32'h1B);
    chk("irq_k0", 32'(irq), 32'h0);
    tick(); tick();
    rd(2'd1, rv);
    chk("irq_done_set", 32'(rv[2]), 32'h1);
    chk("irq_not_yet", 32'(irq), 32'h0);
    tick();
    chk("irq_high", 32'(irq), 32'h1);
    wr(2'd1, 32'h18);
    rd(2'd1, rv);
    chk("irq_done_clr", 32'(rv[2]), 32'h0);
    tick();
    chk("irq_low", 32'(irq), 32'h0);
`endif

    // Completion and a DONE-clearing CTRL write on the same edge.
    wr(2'd2, 32'd2);
    wr(2'd1, 32'h0B);
    tick();
    wr(2'd1, 32'h8);
    rd(2'd1, rv);
    chk("set_wins", rv, 32'h4);
    wr(2'd1, 32'h8);

    // Reset while running at idx 1.
    wr(2'd0, 32'h1);
    wr(2'd3, 32'h2);
    wr(2'd2, 32'd2);
    wr(2'd1, 32'h0101);
    tick(); tick();
    chk("mid_idx1", 32'(out_port), 32'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_out", 32'(out_port), 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rv);
      chk($sformatf("mid_rst_reg%0d", a), rv, 32'h0);
    end
`ifdef HW_NIOS_PIO_SEQ_IRQ_EN
    chk("mid_rst_irq", 32'(irq), 32'h0);
`endif

    // Randomized runs against the step model.
    for (int r = 0; r < 20; r++) begin
      pat = $urandom;
      per = int'($urandom_range(0, 3));
      len = int'($urandom_range(0, 5));
      os  = 1'($urandom_range(0, 1));
      dat = 1'($urandom_range(0, 1));
      cyc = ((per == 0) ? 1 : per) * (len + 1) * 2 + 2;
      wr(2'd0, 32'(dat));
      wr(2'd3, pat);
      wr(2'd2, 32'(per));
      wr(2'd1, (32'(len) << 8) | (32'(os) << 1) | 32'h9);
      for (int k = 0; k < cyc; k++) begin
        chk($sformatf("rand%0d_k%0d", r, k), 32'(out_port),
            32'(model_out(pat, per, len, os, dat, k)));
        tick();
      end
      rd(2'd1, rv);
      chk($sformatf("rand%0d_ctrl", r), {rv[12:8], rv[2:0]},
          {5'(len), os, os, ~os});
      wr(2'd1, 32'h8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
